// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console controller: glyph geometry,
// host control codes and the controller state encoding.
package text_console_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam logic [7:0] CC_BS        = 8'h08;
  localparam logic [7:0] CC_LF        = 8'h0A;
  localparam logic [7:0] CC_CR        = 8'h0D;
  localparam logic [7:0] CC_PRINT_MIN = 8'h20;

  typedef enum logic [1:0] {
    INIT_CLEAR,
    IDLE,
    ROW_CLEAR
  } state_t;

endpackage

// File: rtl/text_console_ctrl_ram.sv
// Simple dual-port cell store: one write port, one synchronous read port.
// A read colliding with a write to the same address returns the old contents.
module text_ram #(
  parameter int DEPTH = 2700,
  parameter int AW    = 12
) (
  input  logic          clk_pixel,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk_pixel) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Text console controller: accepts host characters into a circular-row cell RAM
// and serves the renderer one cell per pixel with a single cycle of latency.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int         COLS         = 90,
  parameter int         ROWS         = 30,
  parameter logic [7:0] BLANK_CHAR   = 8'h20,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic [7:0] in_attr,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  output logic [7:0] character,
  output logic [7:0] attribute,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(CELLS + 1);

  // Logical-to-physical row rotation; both operands are below ROWS so one
  // conditional subtract replaces the modulo.
  function automatic int phys_row(input int lrow, input int top);
    int s;
    s = lrow + top;
    if (s >= ROWS) s = s - ROWS;
    return s;
  endfunction

  state_t          state_q, state_d;
  logic [6:0]      col_q, col_d;
  logic [4:0]      row_q, row_d;
  logic [4:0]      top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            row_adv;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [15:0]     wr_data;
  logic [AW-1:0]   row_base;
  logic            vld_p0, vld_p1;
  logic [AW-1:0]   raddr_p0;
  logic [15:0]     rdata_p1;

  assign row_base = AW'(phys_row(int'(row_q), int'(top_q)) * COLS);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    row_adv = 1'b0;
    wr_en   = 1'b0;
    wr_addr = row_base + AW'(col_q);
    wr_data = {BLANK_CHAR, DEFAULT_ATTR};
    unique case (state_q)
      INIT_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = AW'(cnt_q);
        if (cnt_q == CW'(CELLS - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (in_valid) begin
          if (in_char >= CC_PRINT_MIN) begin
            wr_en   = 1'b1;
            wr_data = {in_char, in_attr};
            if (col_q == 7'(COLS - 1)) begin
              col_d   = '0;
              row_adv = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (in_char)
              CC_LF: begin
                col_d   = '0;
                row_adv = 1'b1;
              end
              CC_CR: col_d = '0;
              CC_BS: if (col_q != 7'd0) col_d = col_q - 7'd1;
              default: ;
            endcase
          end
          // Advancing past the bottom row scrolls by rotating top_q; the row
          // that was on top becomes the new bottom and must be blanked.
          if (row_adv) begin
            if (row_q != 5'(ROWS - 1)) begin
              row_d = row_q + 5'd1;
            end else begin
              top_d   = (top_q == 5'(ROWS - 1)) ? 5'd0 : top_q + 5'd1;
              cnt_d   = '0;
              state_d = ROW_CLEAR;
            end
          end
        end
      end
      ROW_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = row_base + AW'(cnt_q);
        if (cnt_q == CW'(COLS - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = INIT_CLEAR;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      state_q <= INIT_CLEAR;
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      vld_p1  <= vld_p0;
    end
  end

  // p0: pixel coordinates to cell address
  assign vld_p0   = (int'(cx) < COLS * GLYPH_W) && (int'(cy) < ROWS * GLYPH_H);
  assign raddr_p0 = vld_p0 ? AW'(phys_row(int'(cy[9:4]), int'(top_q)) * COLS + int'(cx[9:3]))
                           : '0;

  text_ram #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk_pixel (clk_pixel),
    .we        (wr_en & rst_n),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .raddr     (raddr_p0),
    .rdata     (rdata_p1)
  );

  // p1: registered cell, forced blank outside the text area
  assign character  = vld_p1 ? rdata_p1[15:8] : BLANK_CHAR;
  assign attribute  = vld_p1 ? rdata_p1[7:0]  : 8'h00;

  assign in_ready   = (state_q == IDLE);
  assign busy       = !in_ready;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: a logical-screen model (rows shift on scroll)
// predicts every cycle's outputs under directed and random traffic.
module tb_text_console_ctrl;

  localparam int COLS  = 90;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0]  BLANK = 8'h20;
  localparam logic [15:0] BLANK_CELL = 16'h200F;

  logic       clk_pixel;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic [7:0] in_attr;
  logic [9:0] cx;
  logic [9:0] cy;
  logic [7:0] character;
  logic [7:0] attribute;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  text_console_ctrl dut (
    .clk_pixel  (clk_pixel),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_attr    (in_attr),
    .cx         (cx),
    .cy         (cy),
    .character  (character),
    .attribute  (attribute),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  // Logical screen: row 0 is always what appears at cy=0.
  logic [15:0] scr   [ROWS][COLS];
  bit          known [ROWS][COLS];
  int          m_col, m_row, m_init_left, m_clr_left, m_clr_idx;
  bit          e_ready;
  logic [7:0]  e_char, e_attr;
  bit          e_known;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fill(input bit blank);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        scr[r][c]   = BLANK_CELL;
        known[r][c] = blank;
      end
  endtask

  task automatic advance_row();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) begin
          scr[r][c]   = scr[r+1][c];
          known[r][c] = known[r+1][c];
        end
      // the new bottom row still holds the old top row until cleared
      m_clr_left = COLS;
      m_clr_idx  = 0;
    end
  endtask

  task automatic model_step();
    logic [15:0] saved [COLS];
    bit          saved_k [COLS];
    if (!rst_n || int'(cx) >= COLS * 8 || int'(cy) >= ROWS * 16) begin
      e_char = BLANK; e_attr = 8'h00; e_known = 1'b1;
    end else begin
      {e_char, e_attr} = scr[int'(cy) / 16][int'(cx) / 8];
      e_known = known[int'(cy) / 16][int'(cx) / 8];
    end
    if (!rst_n) begin
      m_col = 0; m_row = 0; m_init_left = CELLS; m_clr_left = 0;
      fill(1'b0);
    end else if (m_init_left > 0) begin
      m_init_left--;
      if (m_init_left == 0) fill(1'b1);
    end else if (m_clr_left > 0) begin
      scr[ROWS-1][m_clr_idx] = BLANK_CELL;
      m_clr_idx++;
      m_clr_left--;
    end else if (in_valid) begin
      if (in_char >= 8'h20) begin
        scr[m_row][m_col]   = {in_char, in_attr};
        known[m_row][m_col] = 1'b1;
        m_col++;
        if (m_col == COLS) begin
          m_col = 0;
          for (int c = 0; c < COLS; c++) begin
            saved[c] = scr[0][c]; saved_k[c] = known[0][c];
          end
          advance_row();
          if (m_clr_left > 0)
            for (int c = 0; c < COLS; c++) begin
              scr[ROWS-1][c] = saved[c]; known[ROWS-1][c] = saved_k[c];
            end
        end
      end else if (in_char == 8'h0A) begin
        m_col = 0;
        for (int c = 0; c < COLS; c++) begin
          saved[c] = scr[0][c]; saved_k[c] = known[0][c];
        end
        advance_row();
        if (m_clr_left > 0)
          for (int c = 0; c < COLS; c++) begin
            scr[ROWS-1][c] = saved[c]; known[ROWS-1][c] = saved_k[c];
          end
      end else if (in_char == 8'h0D) begin
        m_col = 0;
      end else if (in_char == 8'h08) begin
        if (m_col > 0) m_col--;
      end
    end
    e_ready = (m_init_left == 0) && (m_clr_left == 0);
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    model_step();
    @(negedge clk_pixel);
    chk("in_ready", in_ready, e_ready);
    chk("busy", busy, !e_ready);
    chk("cursor_col", cursor_col, m_col);
    chk("cursor_row", cursor_row, m_row);
    if (e_known) begin
      chk("character", character, e_char);
      chk("attribute", attribute, e_attr);
    end
  endtask

  task automatic send(input logic [7:0] ch, input logic [7:0] at);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1; in_char = ch; in_attr = at;
    for (int i = 0; i < 5000 && !done; i++) begin
      done = e_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("send_accepted", done, 1);
  endtask

  task automatic count_busy(input string nm, input int exp);
    int n;
    chk({nm, "_busy_start"}, busy, 1);
    n = 1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (busy) n++;
      else break;
    end
    chk(nm, n, exp);
  endtask

  task automatic peek(input int px, input int py, input logic [7:0] ec, input logic [7:0] ea);
    cx = 10'(px); cy = 10'(py);
    tick();
    chk("peek_char", character, ec);
    chk("peek_attr", attribute, ea);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0; in_valid = 1'b0; in_char = 8'h00; in_attr = 8'h00;
    cx = 10'd0; cy = 10'd0;

    // reset held two cycles, then the full-screen clear
    tick(); tick();
    chk("rst_cursor_col", cursor_col, 0);
    chk("rst_cursor_row", cursor_row, 0);
    chk("rst_character", character, 8'h20);
    chk("rst_attribute", attribute, 8'h00);
    rst_n = 1'b1;
    count_busy("init_busy_len", 2700);
    chk("init_ready", in_ready, 1);
    peek(0, 0, 8'h20, 8'h0F);
    peek(719, 479, 8'h20, 8'h0F);

    // single printable character
    send(8'h41, 8'h1E);
    chk("print_col", cursor_col, 1);
    chk("print_row", cursor_row, 0);
    peek(0, 0, 8'h41, 8'h1E);

    // full line wraps to the next row
    send(8'h0D, 8'h00);
    for (int i = 0; i < COLS; i++) send(8'(8'h21 + i), 8'h07);
    chk("wrap_col", cursor_col, 0);
    chk("wrap_row", cursor_row, 1);
    peek(712, 0, 8'h7A, 8'h07);

    // control codes
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 8'h02);
    chk("ctl_col5", cursor_col, 5);
    send(8'h08, 8'h00);
    chk("bs_col", cursor_col, 4);
    peek(32, 16, 8'h34, 8'h02);
    send(8'h0D, 8'h00);
    chk("cr_col", cursor_col, 0);
    chk("cr_row", cursor_row, 1);
    send(8'h07, 8'h00);
    chk("bel_col", cursor_col, 0);
    chk("bel_row", cursor_row, 1);

    // scroll from the bottom row
    for (int i = 0; i < 28; i++) send(8'h0A, 8'h00);
    chk("pre_scroll_row", cursor_row, 29);
    send(8'h0A, 8'h00);
    count_busy("scroll_busy_len", 90);
    chk("scroll_row", cursor_row, 29);
    chk("scroll_col", cursor_col, 0);
    peek(0, 0, 8'h30, 8'h02);
    peek(0, 464, 8'h20, 8'h0F);

    // outside the text area
    peek(720, 0, 8'h20, 8'h00);
    peek(0, 480, 8'h20, 8'h00);

    // random traffic with random pixel positions
    for (int i = 0; i < 6000; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      in_valid = $urandom_range(0, 1) == 1;
      in_attr  = 8'($urandom);
      if (k < 10)       in_char = 8'($urandom_range(32, 255));
      else if (k == 10) in_char = 8'h0D;
      else if (k == 11) in_char = 8'h08;
      else if (k == 12) in_char = 8'($urandom_range(0, 31));
      else              in_char = 8'h0A;
      cx = 10'($urandom_range(0, 799));
      cy = 10'($urandom_range(0, 524));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 200 && !e_ready; i++) tick();
    chk("random_drain", e_ready, 1);

    // reset in the middle of a row clear
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      send(8'h0A, 8'h00);
      hit = (m_clr_left > 0);
    end
    chk("reached_row_clear", hit, 1);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midclr_col", cursor_col, 0);
    chk("midclr_row", cursor_row, 0);
    count_busy("reinit_busy_len", 2700);
    peek(0, 0, 8'h20, 8'h0F);
    peek(712, 464, 8'h20, 8'h0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
